// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_tb_pkg
// Description : Shared types for the AXI write-slave responder: response
//               encoding, default bus widths and queue entry layouts.
// Revision    : 1.0  initial release
// ============================================================================
package axi_tb_pkg;

    localparam int AXI_ID_W_DEFAULT   = 4;
    localparam int AXI_DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic [AXI_ID_W_DEFAULT-1:0] id;
        logic [7:0]                  len;
    } aw_entry_t;

    typedef struct packed {
        logic [AXI_ID_W_DEFAULT-1:0] id;
        resp_e                       resp;
    } b_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ostd.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ostd
// Description : Small synchronous FIFO for outstanding-request bookkeeping.
//               Supports push and pop in the same cycle. DEPTH must be a
//               power of two so the pointers wrap naturally.
// Ports       : aclk/aresetn (async, active-low) / srst (sync clear)
//               push, push_data      - write side (ignored when full)
//               pop, pop_data        - read side, pop_data shows the head
//               full, empty, count   - occupancy status
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ostd #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_slv_wr_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_slv_wr_responder
// Description : AXI write slave responder. Queues AW requests, sinks W beats
//               against the head request, checks beat count and WID, and
//               returns in-order B responses (OKAY / SLVERR). Sticky error
//               flags err_len / err_id report any protocol violation seen.
// Ports       : aclk, aresetn (async, active-low), srst (sync clear)
//               AW: in_awvalid/out_awready/in_awid/in_awlen
//               W : in_wvalid/out_wready/in_wid/in_wdata/in_wstrb/in_wlast
//               B : out_bvalid/in_bready/out_bid/out_bresp
//               Status: err_len, err_id, ostd_cnt
// Config      : `define SLV_RAND_BP_EN adds LFSR-driven random backpressure
//               on out_awready (lfsr[0]) and out_wready (lfsr[1]).
// Revision    : 1.0  initial release
// ============================================================================
module axi_slv_wr_responder
    import axi_tb_pkg::*;
#(
    parameter int AXI_ID_W        = AXI_ID_W_DEFAULT,
    parameter int AXI_DATA_W      = AXI_DATA_W_DEFAULT,
    parameter int SLV_OSTDREQ_NUM = 4,
    parameter int clk_period      = 5
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           srst,
    input  logic                           in_awvalid,
    output logic                           out_awready,
    input  logic [AXI_ID_W-1:0]            in_awid,
    input  logic [7:0]                     in_awlen,
    input  logic                           in_wvalid,
    output logic                           out_wready,
    input  logic [AXI_ID_W-1:0]            in_wid,
    input  logic [AXI_DATA_W-1:0]          in_wdata,
    input  logic [AXI_DATA_W/8-1:0]        in_wstrb,
    input  logic                           in_wlast,
    output logic                           out_bvalid,
    input  logic                           in_bready,
    output logic [AXI_ID_W-1:0]            out_bid,
    output logic [1:0]                     out_bresp,
    output logic                           err_len,
    output logic                           err_id,
    output logic [$clog2(SLV_OSTDREQ_NUM):0] ostd_cnt
);

    localparam int                c_cnt_w    = $clog2(SLV_OSTDREQ_NUM) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(SLV_OSTDREQ_NUM);

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [7:0]          len;
    } aw_slot_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } b_slot_t;

    // Output skew of the original driver is a simulation artefact; every
    // output here already changes only just after the clock edge.
    generate
        if (clk_period > 0) begin : g_skew_free_outputs
        end
    endgenerate

    aw_slot_t           w_aw_push_data;
    aw_slot_t           w_aw_head;
    logic               w_aw_full;
    logic               w_aw_empty;
    logic [c_cnt_w-1:0] w_aw_count;
    b_slot_t            w_b_push_data;
    b_slot_t            w_b_head;
    logic               w_b_full;
    logic               w_b_empty;
    logic [c_cnt_w-1:0] w_b_count;

    logic               r_awready;
    logic               r_wready;
    logic [8:0]         r_beat_cnt;
    logic               r_id_bad;
    logic               r_err_len;
    logic               r_err_id;

    logic               w_aw_fire;
    logic               w_w_fire;
    logic               w_cnt_hit;
    logic               w_id_ok;
    logic               w_burst_end;
    logic               w_len_ok;
    logic               w_burst_id_bad;
    logic               w_b_pop;
    logic [c_cnt_w-1:0] w_aw_cnt_nxt;
    logic [c_cnt_w-1:0] w_b_cnt_nxt;
    logic               w_bp_aw;
    logic               w_bp_w;
    logic               w_unused_wpayload;

    // Write data and strobes are sunk without being stored.
    assign w_unused_wpayload = ^{in_wdata, in_wstrb, w_aw_full, w_b_full, w_aw_empty};

    assign w_aw_fire      = in_awvalid && r_awready;
    assign w_w_fire       = in_wvalid && r_wready;
    assign w_cnt_hit      = (r_beat_cnt == {1'b0, w_aw_head.len});
    assign w_id_ok        = (in_wid == w_aw_head.id);
    // A burst closes on wlast or on reaching the announced length, whichever
    // comes first; both must coincide for the length to be correct.
    assign w_burst_end    = w_w_fire && (in_wlast || w_cnt_hit);
    assign w_len_ok       = w_cnt_hit && in_wlast;
    assign w_burst_id_bad = r_id_bad || !w_id_ok;
    assign w_b_pop        = !w_b_empty && in_bready;

    assign w_aw_push_data = '{id: in_awid, len: in_awlen};
    assign w_b_push_data  = '{id: w_aw_head.id,
                              resp: (w_len_ok && !w_burst_id_bad) ? OKAY : SLVERR};

    // Occupancy after this edge; ready flops are loaded from these so the
    // registered ready always reflects the queue state it is presented with.
    assign w_aw_cnt_nxt = w_aw_count + c_cnt_w'(w_aw_fire) - c_cnt_w'(w_burst_end);
    assign w_b_cnt_nxt  = w_b_count + c_cnt_w'(w_burst_end) - c_cnt_w'(w_b_pop);

`ifdef SLV_RAND_BP_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_bp_aw    = w_lfsr_nxt[0];
    assign w_bp_w     = w_lfsr_nxt[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= 16'hACE1;
        end else if (srst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_bp_aw = 1'b1;
    assign w_bp_w  = 1'b1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_beat_cnt <= '0;
            r_id_bad   <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_id   <= 1'b0;
        end else if (srst) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_beat_cnt <= '0;
            r_id_bad   <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_id   <= 1'b0;
        end else begin
            r_awready <= (w_aw_cnt_nxt != c_full_cnt) && w_bp_aw;
            r_wready  <= (w_aw_cnt_nxt != '0) && (w_b_cnt_nxt != c_full_cnt) && w_bp_w;
            if (w_w_fire) begin
                if (w_burst_end) begin
                    r_beat_cnt <= '0;
                    r_id_bad   <= 1'b0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 9'd1;
                    r_id_bad   <= w_burst_id_bad;
                end
                if (!w_id_ok) r_err_id <= 1'b1;
            end
            if (w_burst_end && !w_len_ok) r_err_len <= 1'b1;
        end
    end

    sync_fifo_ostd #(
        .WIDTH ($bits(aw_slot_t)),
        .DEPTH (SLV_OSTDREQ_NUM)
    ) u_aw_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push      (w_aw_fire),
        .push_data (w_aw_push_data),
        .pop       (w_burst_end),
        .pop_data  (w_aw_head),
        .full      (w_aw_full),
        .empty     (w_aw_empty),
        .count     (w_aw_count)
    );

    sync_fifo_ostd #(
        .WIDTH ($bits(b_slot_t)),
        .DEPTH (SLV_OSTDREQ_NUM)
    ) u_b_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push      (w_burst_end),
        .push_data (w_b_push_data),
        .pop       (w_b_pop),
        .pop_data  (w_b_head),
        .full      (w_b_full),
        .empty     (w_b_empty),
        .count     (w_b_count)
    );

    assign out_awready = r_awready;
    assign out_wready  = r_wready;
    assign out_bvalid  = !w_b_empty;
    assign out_bid     = w_b_head.id;
    assign out_bresp   = w_b_head.resp;
    assign err_len     = r_err_len;
    assign err_id      = r_err_id;
    assign ostd_cnt    = w_aw_count;

endmodule
`default_nettype wire

// File: doc/axi_slv_wr_responder.md
Name: axi_slv_wr_responder

Overview:
Testbench-side AXI write slave; the responding end of the master write driver.
- Accepts AW requests into an outstanding queue and sinks W beats against the head request.
- Checks beat count and WID for each burst.
- Returns B responses in order with OKAY or SLVERR.
- Sits between the DUT's master port (or the master driver) and the scoreboard, which reads its sticky error flags.

Parameters:
AXI_ID_W, 4, ID width on AW/W/B
AXI_DATA_W, 32, W data width
SLV_OSTDREQ_NUM, 4, AW queue depth and B queue depth; power of 2, at least 2
clk_period, 5, used only for the output skew #(clk_period/5), matching the master driver

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous reset, active-low
srst  in  1  synchronous clear, active-high
in_awvalid  in  1  AW valid
out_awready  out  1  AW ready
in_awid  in  AXI_ID_W  AW id
in_awlen  in  8  AW burst length minus 1
in_wvalid  in  1  W valid
out_wready  out  1  W ready
in_wid  in  AXI_ID_W  W id
in_wdata  in  AXI_DATA_W  W data (sunk, not stored)
in_wstrb  in  AXI_DATA_W/8  W strobes
in_wlast  in  1  W last
out_bvalid  out  1  B valid
in_bready  in  1  B ready
out_bid  out  AXI_ID_W  B id
out_bresp  out  2  B response: 2'b00 OKAY, 2'b10 SLVERR
err_len  out  1  sticky: beat count did not match awlen+1
err_id  out  1  sticky: in_wid did not match the head AW id
ostd_cnt  out  $clog2(SLV_OSTDREQ_NUM)+1  AW entries not yet completed

Behaviour:
Reset:
- aresetn is asynchronous, active-low; clock is aclk.
- srst clears the same state synchronously; srst takes priority over every other event in that cycle.
- On reset all queues are empty and pointers and the beat counter are 0.
- Output reset values: out_bvalid=0, out_bid=0, out_bresp=0, err_len=0, err_id=0, ostd_cnt=0.
- out_awready=1 and out_wready=0 one cycle after reset release.
- Reset mid-burst discards every in-flight AW, W and B entry; no B is issued for them.

AW queue:
- out_awready = !aw_full.
- Push on in_awvalid && out_awready, storing {in_awid, in_awlen}.
- Pop on the cycle the burst-ending W beat is accepted.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo SLV_OSTDREQ_NUM.

W acceptance:
- out_wready = !aw_empty && !b_full.
- A W beat presented before its AW has been accepted is back-pressured, never accepted.

Beat counter:
- 9-bit counter, incremented on each accepted beat.
- Cleared on the burst-ending beat.

Burst end:
- A burst ends on an accepted beat where in_wlast=1, or where beat_cnt==head_len.
- On that beat, compare len_ok = (beat_cnt==head_len) && in_wlast.
- On each accepted beat, compare id_ok = (in_wid==head_id); any mismatch within the burst latches an id_bad flag, cleared at burst end.
- Response is OKAY if len_ok && !id_bad, else SLVERR.
- err_len and err_id set on the corresponding failure and stay set until reset.

B queue:
- Push {head_id, resp} at burst end.
- out_bvalid = !b_empty; out_bid/out_bresp driven from the head entry; pop on out_bvalid && in_bready.
- Earliest B: one cycle after the last W beat is accepted (registered).
- Once asserted, out_bvalid and its payload stay stable until in_bready.
- Simultaneous push and pop: count unchanged.

ostd_cnt:
- +1 on AW push, -1 on burst end, unchanged when both occur in the same cycle.

Output timing:
- All outputs are driven from flops updated on posedge aclk, with #(clk_period/5) skew.

Optional Feature:
SLV_RAND_BP_EN
- Defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
- out_awready is additionally ANDed with lfsr[0]; out_wready is additionally ANDed with lfsr[1].
- The LFSR is reset by aresetn/srst.
- Undefined: no LFSR; ready is purely queue-status based.

Decomposition:
Package axi_tb_pkg holds:
- resp_e enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
- AXI_ID_W and AXI_DATA_W defaults
- aw_entry_t {id, len} and b_entry_t {id, resp} struct typedefs

Sub-module: sync_fifo_ostd (parameterised width and depth, full/empty, simultaneous push/pop), instantiated twice, for the AW queue and the B queue.

Test Plan:
- Single burst: AW id=4'h5 len=3, 4 beats with wlast on beat 4, bready=1 → one B cycle after the last beat, bid=5, bresp=OKAY, ostd_cnt back to 0.
- Queue full: 4 AWs (ids 0–3, len=0) with wvalid=0 → awready=0 after the 4th AW, ostd_cnt=4; then W beats → B responses in order with ids 0,1,2,3.
- Early wlast: AW len=7, wlast on beat 3 → bresp=SLVERR, err_len=1 (sticky), following burst returns OKAY.
- Wrong id: AW id=2 len=1, beats with wid=3 → bresp=SLVERR, bid=2, err_id=1.
- B backpressure: bready=0 with 4 completed bursts → wready=0 while the B queue is full; release bready → all 4 B responses drained, wready returns to 1.
- Reset mid-burst: aresetn low after 2 of 4 beats → all outputs at reset values, no B issued; next full burst → OKAY.
